rst_stretch_sync: RTL

Reset request conditioner that generates the synchronous, active-high reset consumed by the design's sync-reset flops. It accepts an asynchronous reset request from a foreign clock domain and a synchronous software request, and synchronizes the async one into `clk`. It then drives a registered reset output held high for a guaranteed minimum of `STRETCH` cycles, so every downstream flop sees at least one active edge with reset asserted. A handshake-style `busy`/`done` pair lets sequencing logic know when the domain is out of reset.

---
 rtl/rst_stretch_sync_if.sv | 24 ++
 rtl/rst_stretch_sync.sv | 108 ++++++++++
 2 files changed

// File: rtl/rst_stretch_sync_if.sv
// Request/status bundle for rst_stretch_sync: reset requests in, conditioned reset and status out.
interface rst_stretch_sync_if;
  logic req_async;
  logic sw_req;
  logic rst_out;
  logic busy;
  logic done;

  modport master (
    output req_async,
    output sw_req,
    input  rst_out,
    input  busy,
    input  done
  );

  modport slave (
    input  req_async,
    input  sw_req,
    output rst_out,
    output busy,
    output done
  );
endinterface

// File: rtl/rst_stretch_sync.sv
// Reset request conditioner: synchronizes req_async, merges sw_req, stretches rst_out to >= STRETCH cycles.
// Optional: define RST_STRETCH_RETRIGGER_EN to let new requests restart the stretch while busy.
module rst_stretch_sync #(
  parameter int SYNC_STAGES = 2,
  parameter int STRETCH     = 16
) (
  input  logic              clk,
  input  logic              rst,
  rst_stretch_sync_if.slave bus
);

  localparam int CW = (STRETCH <= 2) ? 1 : $clog2(STRETCH);
  localparam logic [CW-1:0] CNT_LOAD = CW'(STRETCH - 1);

  typedef enum logic [1:0] {
    S_IDLE,
    S_ASSERT,
    S_HOLD
  } state_t;

  logic [SYNC_STAGES-1:0] r_sync;
  logic                   r_req_s_d;
  state_t                 r_state;
  logic [CW-1:0]          r_cnt;
  logic                   r_rst_out;
  logic                   r_busy;
  logic                   r_done;

  logic                   w_req_s;
  logic                   w_trig;
  state_t                 w_state_next;
  logic [CW-1:0]          w_cnt_next;
  logic                   w_done_next;

  assign w_req_s = r_sync[SYNC_STAGES-1];
  assign w_trig  = (w_req_s & ~r_req_s_d) | bus.sw_req;

  always_comb begin
    w_state_next = r_state;
    w_cnt_next   = r_cnt;
    w_done_next  = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (w_trig) begin
          w_state_next = S_ASSERT;
          w_cnt_next   = CNT_LOAD;
        end
      end
      S_ASSERT: begin
`ifdef RST_STRETCH_RETRIGGER_EN
        if (w_trig) begin
          w_cnt_next = CNT_LOAD;
        end else
`endif
        if (r_cnt != '0) begin
          w_cnt_next = r_cnt - CW'(1);
        end else if (w_req_s) begin
          // Request still asserted at the end of the stretch: keep reset on until it drops.
          w_state_next = S_HOLD;
        end else begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      S_HOLD: begin
`ifdef RST_STRETCH_RETRIGGER_EN
        if (bus.sw_req) begin
          w_state_next = S_ASSERT;
          w_cnt_next   = CNT_LOAD;
        end else
`endif
        if (!w_req_s) begin
          w_state_next = S_IDLE;
          w_done_next  = 1'b1;
        end
      end
      default: begin
        w_state_next = S_IDLE;
      end
    endcase
  end

  // Outputs are registered from the next state so they change on the same edge as the state.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_sync    <= '0;
      r_req_s_d <= 1'b0;
      r_state   <= S_ASSERT;
      r_cnt     <= CNT_LOAD;
      r_rst_out <= 1'b1;
      r_busy    <= 1'b1;
      r_done    <= 1'b0;
    end else begin
      r_sync    <= {r_sync[SYNC_STAGES-2:0], bus.req_async};
      r_req_s_d <= w_req_s;
      r_state   <= w_state_next;
      r_cnt     <= w_cnt_next;
      r_rst_out <= (w_state_next != S_IDLE);
      r_busy    <= (w_state_next != S_IDLE);
      r_done    <= w_done_next;
    end
  end

  assign bus.rst_out = r_rst_out;
  assign bus.busy    = r_busy;
  assign bus.done    = r_done;

endmodule
